exp_req_ctrl: RTL and testbench

// Upstream feeder for the CP0 exception block. Takes three asynchronous external interrupt lines, synchronises them and edge-detects them.

---
 rtl/exp_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_exp_req_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exp_req_ctrl
//  Description : Interrupt front end for the CP0 exception block. It
//                synchronises and edge-detects three external IRQ lines and
//                latches each rising edge as a pending event. It issues one
//                prioritised request at a time on expsrc0..2, then waits for
//                exp_ack followed by eret_commit. A guaranteed all-low gap
//                follows before the next request.
//  Revision    : 1.0  initial release
// ============================================================================
module exp_req_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] irq_in,
    input  logic [2:0] src_block,
    input  logic       expblock,
    input  logic       exp_ack,
    input  logic       eret_commit,
    output logic       expsrc0,
    output logic       expsrc1,
    output logic       expsrc2,
    output logic [2:0] pending,
    output logic [2:0] in_service,
    output logic       busy
);

    localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync_q [SYNC_STAGES];
    logic [2:0]      hist_q;
    logic [2:0]      pending_q, pending_d;
    logic [2:0]      in_service_q, in_service_d;
    logic [2:0]      expsrc_q, expsrc_d;
    logic [1:0]      sel_q, sel_d;
    logic [CW-1:0]   gap_q, gap_d;

    logic [2:0]      w_rise;
    logic [2:0]      w_clr;
    logic [2:0]      w_elig;
    logic [1:0]      w_pick;

    // Synchroniser chain per line plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 3'b000;
            hist_q <= 3'b000;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign w_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // A new edge overrides an acknowledge-clear on the same source.
    assign pending_d = (pending_q & ~w_clr) | w_rise;

    // Eligible requests with fixed priority: source 0 is the highest.
    assign w_elig = expblock ? 3'b000 : (pending_q & ~src_block);
    assign w_pick = w_elig[0] ? 2'd0 : (w_elig[1] ? 2'd1 : 2'd2);

    // Request FSM next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        expsrc_d     = expsrc_q;
        in_service_d = in_service_q;
        gap_d        = gap_q;
        w_clr        = 3'b000;
        unique case (state_q)
            ST_IDLE: begin
                expsrc_d = 3'b000;
                if (w_elig != 3'b000) begin
                    sel_d    = w_pick;
                    expsrc_d = 3'b001 << w_pick;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // The acknowledge wins over a same-cycle mask abort.
                if (exp_ack) begin
                    w_clr        = 3'b001 << sel_q;
                    in_service_d = 3'b001 << sel_q;
                    expsrc_d     = 3'b000;
                    state_d      = ST_SERVICE;
                end else if (expblock || src_block[sel_q]) begin
                    expsrc_d = 3'b000;
                    state_d  = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                expsrc_d = 3'b000;
                if (eret_commit) begin
                    in_service_d = 3'b000;
                    gap_d        = CW'(GAP_CYCLES);
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                expsrc_d = 3'b000;
                if (gap_q <= CW'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - CW'(1);
                end
            end
            default: begin
                expsrc_d = 3'b000;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= 2'd0;
            expsrc_q     <= 3'b000;
            in_service_q <= 3'b000;
            pending_q    <= 3'b000;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            expsrc_q     <= expsrc_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            gap_q        <= gap_d;
        end
    end

    assign expsrc0    = expsrc_q[0];
    assign expsrc1    = expsrc_q[1];
    assign expsrc2    = expsrc_q[2];
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exp_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_req_ctrl
//  Description : Directed self-checking bench for exp_req_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exp_req_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] irq_in;
    logic [2:0] src_block;
    logic       expblock;
    logic       exp_ack;
    logic       eret_commit;
    logic       expsrc0, expsrc1, expsrc2;
    logic [2:0] pending;
    logic [2:0] in_service;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    exp_req_ctrl #(.SYNC_STAGES(2), .GAP_CYCLES(2)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .src_block   (src_block),
        .expblock    (expblock),
        .exp_ack     (exp_ack),
        .eret_commit (eret_commit),
        .expsrc0     (expsrc0),
        .expsrc1     (expsrc1),
        .expsrc2     (expsrc2),
        .pending     (pending),
        .in_service  (in_service),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] req();
        return {expsrc2, expsrc1, expsrc0};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_once();
        exp_ack = 1'b1;
        tick();
        exp_ack = 1'b0;
    endtask

    // ERET plus enough cycles for the gap to expire back to IDLE.
    task automatic eret_and_drain();
        eret_commit = 1'b1;
        tick();
        eret_commit = 1'b0;
        tick(4);
    endtask

    initial begin
        reset = 1'b0; irq_in = 3'b000; src_block = 3'b000;
        expblock = 1'b0; exp_ack = 1'b0; eret_commit = 1'b0;
        tick(3);
        chk("rst_expsrc", 8'(req()), 8'h0);
        chk("rst_pending", 8'(pending), 8'h0);
        chk("rst_insvc", 8'(in_service), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        reset = 1'b1;
        tick();

        // T1: three-clock pulse on source 1
        irq_in = 3'b010;
        tick();                                     // E0
        chk("t1_pend_e0", 8'(pending), 8'h0);
        tick();                                     // E1
        chk("t1_pend_e1", 8'(pending), 8'h0);
        tick();                                     // E2
        chk("t1_pend_e2", 8'(pending), 8'h2);
        chk("t1_req_e2", 8'(req()), 8'h0);
        irq_in = 3'b000;
        tick();                                     // E3
        chk("t1_req_e3", 8'(req()), 8'h2);
        chk("t1_busy", 8'(busy), 8'h1);
        tick(3);
        chk("t1_req_hold", 8'(req()), 8'h2);
        ack_once();
        chk("t1_req_ack", 8'(req()), 8'h0);
        chk("t1_insvc", 8'(in_service), 8'h2);
        chk("t1_pend_ack", 8'(pending), 8'h0);
        eret_commit = 1'b1;
        tick();
        eret_commit = 1'b0;
        chk("t1_insvc_eret", 8'(in_service), 8'h0);
        tick(4);
        chk("t1_idle", 8'(busy), 8'h0);

        // T2: source 2 then source 0 one cycle later, held off until both pend
        expblock = 1'b1;
        irq_in = 3'b100;
        tick();
        irq_in = 3'b101;
        tick(4);
        chk("t2_pend_both", 8'(pending), 8'h5);
        chk("t2_req_blocked", 8'(req()), 8'h0);
        expblock = 1'b0;
        irq_in = 3'b000;
        tick();
        chk("t2_req_src0", 8'(req()), 8'h1);
        ack_once();
        chk("t2_insvc0", 8'(in_service), 8'h1);
        chk("t2_pend_left", 8'(pending), 8'h4);
        eret_commit = 1'b1;
        tick();
        eret_commit = 1'b0;
        chk("t2_gap0", 8'(req()), 8'h0);
        tick();
        chk("t2_gap1", 8'(req()), 8'h0);
        tick();
        chk("t2_gap2", 8'(req()), 8'h0);
        tick();
        chk("t2_req_src2", 8'(req()), 8'h4);
        ack_once();
        eret_and_drain();
        chk("t2_idle", 8'(busy), 8'h0);

        // T3: masked source retained, then released
        src_block = 3'b001;
        irq_in = 3'b001;
        tick(3);
        chk("t3_pend_masked", 8'(pending), 8'h1);
        tick(2);
        chk("t3_req_masked", 8'(req()), 8'h0);
        chk("t3_busy_masked", 8'(busy), 8'h0);
        src_block = 3'b000;
        irq_in = 3'b000;
        tick();
        chk("t3_req_unmask", 8'(req()), 8'h1);
        ack_once();
        eret_and_drain();

        // T4: expblock aborts a request for source 1
        irq_in = 3'b010;
        tick(4);
        chk("t4_req", 8'(req()), 8'h2);
        expblock = 1'b1;
        irq_in = 3'b000;
        tick();
        chk("t4_req_abort", 8'(req()), 8'h0);
        chk("t4_busy_abort", 8'(busy), 8'h0);
        chk("t4_pend_kept", 8'(pending), 8'h2);
        tick();
        chk("t4_req_still_off", 8'(req()), 8'h0);
        expblock = 1'b0;
        tick();
        chk("t4_req_reissue", 8'(req()), 8'h2);
        ack_once();
        eret_and_drain();

        // T5: new source-2 edge on the same edge as its acknowledge
        irq_in = 3'b100;
        tick();
        irq_in = 3'b000;
        tick(3);
        chk("t5_req", 8'(req()), 8'h4);
        irq_in = 3'b100;
        tick(2);                                    // E0, E1 of second edge
        exp_ack = 1'b1;
        tick();                                     // E2 coincides with ack
        exp_ack = 1'b0;
        irq_in = 3'b000;
        chk("t5_pend_setwins", 8'(pending), 8'h4);
        chk("t5_insvc", 8'(in_service), 8'h4);
        eret_commit = 1'b1;
        tick();
        eret_commit = 1'b0;
        tick(2);
        chk("t5_gap", 8'(req()), 8'h0);
        tick();
        chk("t5_req_second", 8'(req()), 8'h4);
        ack_once();
        eret_and_drain();
        chk("t5_idle_pend", 8'(pending), 8'h0);

        // T6: reset while in SERVICE with source 1 held high
        irq_in = 3'b010;
        tick(4);
        chk("t6_req", 8'(req()), 8'h2);
        ack_once();
        chk("t6_insvc", 8'(in_service), 8'h2);
        reset = 1'b0;
        tick();
        chk("t6_rst_req", 8'(req()), 8'h0);
        chk("t6_rst_pend", 8'(pending), 8'h0);
        chk("t6_rst_insvc", 8'(in_service), 8'h0);
        chk("t6_rst_busy", 8'(busy), 8'h0);
        reset = 1'b1;
        tick(3);
        chk("t6_pend_after", 8'(pending), 8'h2);
        tick();
        chk("t6_req_after", 8'(req()), 8'h2);
        ack_once();
        tick(6);
        chk("t6_pend_once", 8'(pending), 8'h0);
        eret_and_drain();
        tick(4);
        chk("t6_no_second_req", 8'(req()), 8'h0);
        chk("t6_no_second_busy", 8'(busy), 8'h0);
        irq_in = 3'b000;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
